// File: rtl/naive_cpu_if.sv
// naive_cpu_if: instruction ROM bus between the core (master) and the ROM (slave).
interface naive_cpu_if;
    logic [15:0] rom_addr_o;
    logic        rom_ce_o;
    logic [15:0] rom_data_i;
    modport master (output rom_addr_o, rom_ce_o, input rom_data_i);
    modport slave  (input rom_addr_o, rom_ce_o, output rom_data_i);
endinterface

// File: rtl/naive_cpu.sv
// naive_cpu: 5-stage in-order 16-bit core (IF ID EX MEM WB) fetching from an external ROM,
// with operand forwarding into ID and a combinational observer port.
module naive_cpu (
    input  logic        clk,
    input  logic        rst,
    naive_cpu_if.master bus,
    input  logic [3:0]  ob_sel,
    input  logic [2:0]  ob_mode,
    output logic [15:0] ob_data_o
);
    localparam logic [15:0] NOP = 16'h0000;
    typedef enum logic [1:0] {ALU_OR, ALU_AND, ALU_XOR, ALU_ADD} alu_t;

    logic [15:0] pc;
    logic        ce;
    logic [15:0] if_id;
    logic        id_we;
    alu_t        id_op;
    logic [15:0] id_a, id_b;
    logic        ie_we;
    logic [3:0]  ie_rd;
    alu_t        ie_op;
    logic [15:0] ie_a, ie_b;
    logic [15:0] ex_res;
    logic        em_we;
    logic [3:0]  em_rd;
    logic [15:0] em_res;
    logic        mw_we;
    logic [3:0]  mw_rd;
    logic [15:0] mw_data;
    logic [15:0] regs [16];
    logic [3:0]  rsel [2];
    logic [15:0] rval [2];

    assign bus.rom_addr_o = pc;
    assign bus.rom_ce_o   = ce;
    assign rsel[0] = if_id[9:6];
    assign rsel[1] = if_id[5:2];

    // Youngest producer wins; the MEM/WB term doubles as the write-through regfile bypass.
    for (genvar i = 0; i < 2; i++) begin : g_rd
        assign rval[i] = rsel[i] == 4'd0                ? 16'd0 :
                         ie_we && ie_rd == rsel[i]      ? ex_res :
                         em_we && em_rd == rsel[i]      ? em_res :
                         mw_we && mw_rd == rsel[i]      ? mw_data :
                         regs[rsel[i]];
    end

    always_comb begin
        id_we = 1'b1;
        id_op = ALU_OR;
        id_a  = rval[0];
        id_b  = {10'd0, if_id[5:0]};
        case (if_id[15:10])
            6'b000000: begin
                id_op = alu_t'(if_id[1:0]);
                id_b  = rval[1];
            end
            6'b001101: id_op = ALU_OR;
            6'b001100: id_op = ALU_AND;
            6'b001110: id_op = ALU_XOR;
            6'b001000: id_op = ALU_ADD;
            6'b001111: begin
                id_a = 16'd0;
                id_b = {if_id[5:0], 10'd0};
            end
            default:   id_we = 1'b0;
        endcase
        id_we = id_we && if_id[9:6] != 4'd0;
    end

    always_comb
        ex_res = ie_op == ALU_OR  ? ie_a | ie_b :
                 ie_op == ALU_AND ? ie_a & ie_b :
                 ie_op == ALU_XOR ? ie_a ^ ie_b : ie_a + ie_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= 16'd0;
            ce      <= 1'b0;
            if_id   <= NOP;
            ie_we   <= 1'b0;
            ie_rd   <= 4'd0;
            ie_op   <= ALU_OR;
            ie_a    <= 16'd0;
            ie_b    <= 16'd0;
            em_we   <= 1'b0;
            em_rd   <= 4'd0;
            em_res  <= 16'd0;
            mw_we   <= 1'b0;
            mw_rd   <= 4'd0;
            mw_data <= 16'd0;
            regs    <= '{default: 16'd0};
        end else begin
            ce      <= 1'b1;
            pc      <= ce ? pc + 16'd1 : 16'd0;
            if_id   <= ce ? bus.rom_data_i : NOP;
            ie_we   <= id_we;
            ie_rd   <= if_id[9:6];
            ie_op   <= id_op;
            ie_a    <= id_a;
            ie_b    <= id_b;
            em_we   <= ie_we;
            em_rd   <= ie_rd;
            em_res  <= ex_res;
            mw_we   <= em_we;
            mw_rd   <= em_rd;
            mw_data <= em_res;
            if (mw_we) regs[mw_rd] <= mw_data;
        end
    end

    assign ob_data_o = ob_mode == 3'd0 ? (ob_sel == 4'd0 ? 16'd0 : regs[ob_sel]) :
                       ob_mode == 3'd1 ? pc :
                       ob_mode == 3'd2 ? if_id :
                       ob_mode == 3'd3 ? em_res :
                       ob_mode == 3'd4 ? mw_data : 16'd0;
endmodule

// File: tb/tb_naive_cpu.sv
// tb_naive_cpu: scoreboard bench; an architectural model queues per-stage expectations at fetch time.
module tb_naive_cpu;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  ob_sel = 4'd0;
    logic [2:0]  ob_mode = 3'd0;
    logic [15:0] ob_data;
    logic [15:0] mem [256];

    naive_cpu_if bus();
    assign bus.rom_data_i = mem[bus.rom_addr_o[7:0]];

    naive_cpu dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ob_sel(ob_sel), .ob_mode(ob_mode), .ob_data_o(ob_data)
    );

    always #25 clk = ~clk;

    typedef struct {int due; logic [3:0] rd; logic [15:0] val;} ent_t;
    ent_t        iq[$], xq[$], bq[$], wq[$];
    ent_t        me;
    logic [15:0] arch [16];
    logic [15:0] cm [16];
    logic [15:0] mv, sv;
    int          cyc = 0, n_tests = 0, n_fail = 0;
    logic [15:0] exp_pc = 16'd0;
    logic        exp_ce = 1'b0;
    bit          mon_en = 1'b0;

    localparam logic [5:0] OP_ORI = 6'b001101, OP_ADDI = 6'b001000, OP_XORI = 6'b001110,
                           OP_ANDI = 6'b001100, OP_LUI = 6'b001111;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic peek(input logic [2:0] m, input logic [3:0] s, output logic [15:0] v);
        ob_mode = m;
        ob_sel  = s;
        #1 v = ob_data;
    endtask

    function automatic logic [15:0] ei(input logic [5:0] op, input logic [3:0] rd, input logic [5:0] imm);
        return {op, rd, imm};
    endfunction

    function automatic logic [15:0] er(input logic [3:0] rd, input logic [3:0] rs, input logic [1:0] f);
        return {6'b000000, rd, rs, f};
    endfunction

    // Sequential reference execution; results become visible per stage at fixed offsets.
    task automatic fetch(input logic [15:0] ins);
        logic [3:0]  rd = ins[9:6];
        logic [15:0] a = arch[ins[9:6]];
        logic [15:0] b = arch[ins[5:2]];
        logic [15:0] imm = {10'd0, ins[5:0]};
        logic [15:0] v = 16'd0;
        logic        we = 1'b1;
        case (ins[15:10])
            OP_ORI:  v = a | imm;
            OP_ANDI: v = a & imm;
            OP_XORI: v = a ^ imm;
            OP_ADDI: v = a + imm;
            OP_LUI:  v = {ins[5:0], 10'd0};
            6'b000000:
                case (ins[1:0])
                    2'd0:    v = a | b;
                    2'd1:    v = a & b;
                    2'd2:    v = a ^ b;
                    default: v = a + b;
                endcase
            default: we = 1'b0;
        endcase
        iq.push_back('{cyc + 1, 4'd0, ins});
        if (we && rd != 4'd0) begin
            arch[rd] = v;
            xq.push_back('{cyc + 3, rd, v});
            bq.push_back('{cyc + 4, rd, v});
            wq.push_back('{cyc + 5, rd, v});
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            exp_pc = 16'd0;
            exp_ce = 1'b0;
        end else begin
            exp_pc = exp_ce ? exp_pc + 16'd1 : 16'd0;
            exp_ce = 1'b1;
        end
    end

    always @(negedge clk) if (rst && mon_en) begin
        check("pc", bus.rom_addr_o, exp_pc);
        check("rom_ce", {15'd0, bus.rom_ce_o}, {15'd0, exp_ce});
        if (bus.rom_ce_o) fetch(bus.rom_data_i);
        while (wq.size() > 0 && wq[0].due == cyc) begin
            me = wq.pop_front();
            cm[me.rd] = me.val;
        end
        while (iq.size() > 0 && iq[0].due == cyc) begin
            me = iq.pop_front();
            peek(3'd2, 4'd0, mv);
            check("if_id", mv, me.val);
        end
        while (xq.size() > 0 && xq[0].due == cyc) begin
            me = xq.pop_front();
            peek(3'd3, 4'd0, mv);
            check("ex_mem", mv, me.val);
        end
        while (bq.size() > 0 && bq[0].due == cyc) begin
            me = bq.pop_front();
            peek(3'd4, 4'd0, mv);
            check("mem_wb", mv, me.val);
        end
        for (int r = 0; r < 16; r++) begin
            peek(3'd0, 4'(r), mv);
            check($sformatf("r%0d", r), mv, cm[r]);
        end
    end

    task automatic reset_dut(input bit chk);
        mon_en = 1'b0;
        rst = 1'b0;
        iq.delete(); xq.delete(); bq.delete(); wq.delete();
        for (int i = 0; i < 16; i++) begin
            arch[i] = 16'd0;
            cm[i]   = 16'd0;
        end
        repeat (4) @(negedge clk);
        if (chk) begin
            check("rst_ce", {15'd0, bus.rom_ce_o}, 16'd0);
            check("rst_pc", bus.rom_addr_o, 16'd0);
            for (int r = 0; r < 16; r++) begin
                peek(3'd0, 4'(r), sv);
                check($sformatf("rst_r%0d", r), sv, 16'd0);
            end
        end
        @(posedge clk);
        #5 rst = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;
    endtask

    task automatic run_check(input int n, input logic [3:0] r, input logic [15:0] exp, input string tag);
        repeat (n) @(posedge clk);
        #1 peek(3'd0, r, sv);
        check(tag, sv, exp);
    endtask

    initial begin
        fill_nop();
        reset_dut(1'b1);

        for (int i = 0; i < 256; i++) mem[i] = ei(OP_ORI, 4'd1, 6'd3);
        run_check(12, 4'd1, 16'd3, "ori_r1");
        #1 peek(3'd0, 4'd2, sv);
        check("ori_r2", sv, 16'd0);

        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("async_pc", bus.rom_addr_o, 16'd0);
        check("async_ce", {15'd0, bus.rom_ce_o}, 16'd0);
        peek(3'd0, 4'd1, sv);
        check("async_r1", sv, 16'd0);
        reset_dut(1'b0);
        run_check(12, 4'd1, 16'd3, "restart_r1");

        fill_nop();
        for (int i = 0; i < 4; i++) mem[i] = ei(OP_ADDI, 4'd2, 6'd1);
        reset_dut(1'b0);
        run_check(12, 4'd2, 16'd4, "fwd_r2");

        fill_nop();
        mem[0] = ei(OP_ORI, 4'd3, 6'd5);
        mem[1] = ei(OP_ORI, 4'd4, 6'd6);
        mem[2] = er(4'd3, 4'd4, 2'd3);
        mem[3] = er(4'd6, 4'd3, 2'd3);
        mem[4] = er(4'd3, 4'd3, 2'd2);
        mem[5] = ei(OP_ORI, 4'd0, 6'd7);
        mem[6] = er(4'd8, 4'd6, 2'd1);
        reset_dut(1'b0);
        run_check(14, 4'd6, 16'd11, "add_r6");
        run_check(0, 4'd3, 16'd0, "xor_r3");
        run_check(0, 4'd0, 16'd0, "r0_zero");
        run_check(0, 4'd8, 16'd0, "and_r8");

        fill_nop();
        mem[0] = ei(OP_LUI, 4'd5, 6'd63);
        for (int i = 1; i <= 17; i++) mem[i] = ei(OP_ADDI, 4'd5, 6'd63);
        mem[18] = ei(OP_ORI, 4'd7, 6'd5);
        mem[19] = ei(OP_LUI, 4'd7, 6'd63);
        reset_dut(1'b0);
        run_check(28, 4'd5, 16'h002F, "wrap_r5");
        run_check(0, 4'd7, 16'hFC00, "lui_r7");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/naive_cpu.md
Name: naive_cpu

Overview:
- Minimal 5-stage in-order pipelined CPU core (IF, ID, EX, MEM, WB): 16-bit instructions, 16 x 16-bit register file.
- Fetches from an external instruction ROM; has no data memory, so MEM is a pass-through stage.
- Provides an observer port for reading architectural and pipeline state without halting.
- Top level of the CPU; the testbench or board wrapper supplies the ROM.

Parameters:
- none; all widths are fixed: instruction 16, instruction address 16, register 16, register address 4.

Ports:
- clk  input  1  rising-edge clock for all state
- rst  input  1  asynchronous active-low reset
- rom_data_i  input  16  instruction word at rom_addr_o
- rom_addr_o  output  16  current PC
- rom_ce_o  output  1  ROM chip enable
- ob_sel  input  4  register index for observer mode 0
- ob_mode  input  3  observer source select
- ob_data_o  output  16  observed value (combinational)

Behaviour:
- Reset (rst=0, async):
  - PC=0, rom_ce_o=0.
  - All pipeline registers hold NOP (no write-enable).
  - All 16 registers = 0.
- After reset release:
  - rom_ce_o=1 from the first rising edge.
  - rom_addr_o=0 during the first fetch cycle.
  - PC += 1 each cycle (word addressing), wrapping FFFF->0000.
  - While rom_ce_o=0, PC is held at 0 and a NOP is injected into IF/ID.
- Instruction format: op=[15:10], rd=[9:6], low=[5:0].
- I-type: rd <= rd OP zext(imm6).
  - 001101 ORI: OR.
  - 001100 ANDI: AND.
  - 001110 XORI: XOR.
  - 001000 ADDI: add, mod 2^16, no flags.
  - 001111 LUI: rd <= {imm6,10'b0}; the source register is ignored.
- R-type, op=000000: rs=[5:2], f=[1:0]; rd <= rd OP rs.
  - f=00 OR, 01 AND, 10 XOR, 11 ADD.
- Any other opcode is a NOP: no register write.
- No branches; no stalls are ever generated.
- Register file:
  - Two combinational read ports used by ID; one write port used by WB on the rising edge.
  - Register r0 is hardwired to 0: writes are ignored and reads return 0.
  - Same-cycle WB write and ID read of the same register returns the new value.
- Forwarding into ID, priority EX result > MEM result > WB/regfile. Consequences:
  - Back-to-back dependent instructions see correct values.
  - Forwarding never targets r0.
- Latency: an instruction presented on rom_data_i is captured into IF/ID at edge k and moves to ID/EX at k+1, EX/MEM at k+2, MEM/WB at k+3. Its register write lands at edge k+4.
- Observer (ob_data_o, combinational):
  - mode 0: reg[ob_sel], with r0 reading 0.
  - mode 1: PC.
  - mode 2: IF/ID instruction.
  - mode 3: EX/MEM result.
  - mode 4: MEM/WB write data.
  - modes 5-7: 0.
- Reset mid-operation: all in-flight instructions are discarded and register contents are lost; no partial write occurs.

Test Plan:
- Reset check: rst=0 for 4 cycles -> rom_ce_o=0, rom_addr_o=0, ob_mode=0 reads 0 for every ob_sel 0..15. Release rst -> rom_addr_o reads 0,1,2,3… on successive cycles.
- Constant stream of ORI r1,3 (0x3443), ob_mode=0, ob_sel=1:
  - r1 reads 0 until 4 edges after the first capture, then 3, and stays 3.
  - ob_sel=2 reads 0 throughout.
- Forwarding chain ADDI r2,1 x4 back-to-back, then NOPs -> r2=4 after the last writeback. Intermediate EX results via ob_mode 3: 1,2,3,4.
- R-type and r0:
  - ORI r3,5; ORI r4,6; ADD r3,r4 -> r3=11.
  - XOR r3,r3 -> r3=0.
  - ORI r0,7 -> r0 still reads 0.
- LUI and wrap:
  - LUI r5,63 -> r5=0xFC00.
  - ADDI r5,63 x17 -> r5 wraps: 0xFC00 + 1071 = 0x002F.
- Async reset mid-stream: pull rst low between clock edges during the ORI stream -> PC, rom_ce_o and r1 go to 0 immediately, without waiting for an edge. Pipeline restarts cleanly after release.
